// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction memory, queues {pc, inst} for decode.
// Latency: an instruction fetched in cycle N is presented on inst_* in cycle N+1; after a redirect, the first new instruction is valid 2 cycles later.
// Backpressure: inst_ready low fills the queue, which drops imem_enable and freezes the PC; the head holds stable. Optional macro: FETCH_ALIGN_CHECK_EN (adds err port).

// Small generic FIFO with flush. Head read comes straight from storage (no bypass).
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic             head_vld,
   output logic [WIDTH-1:0] head_dat,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign head_vld = (count != '0);
   assign head_dat = store[rd_ptr];
   assign do_pop   = pop & head_vld & ~flush;
   // A pop in the same cycle frees the slot the push is about to use.
   assign full     = (count == (AW+1)'(DEPTH)) & ~do_pop;
   assign do_push  = push_vld & ~full & ~flush;

   // Storage write; cleared on reset so the head outputs read zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            store[i] <= '0;
         end
      end else if (do_push) begin
         store[wr_ptr] <= push_dat;
      end
   end

   // Pointer and occupancy tracking; flush empties the queue outright.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

module fetch_unit #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FQ_DEPTH   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic                  imem_enable,
   output logic                  imem_wr,
   output logic [15:0]           imem_data_in,
   input  logic [15:0]           imem_data_out,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [15:0]           inst_out,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   output logic [ADDR_WIDTH-1:0] inst_pc_plus2,
   output logic                  halted
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic                  err
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [15:0]           inst;
   } fq_entry_t;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] redirect_pc_al;
   logic                  fq_full;
   logic                  fq_push;
   logic                  fq_pop;
   logic                  is_halt;
   fq_entry_t             fq_in;
   fq_entry_t             fq_head;

   // Memory port is read-only from this stage.
   assign imem_wr      = 1'b0;
   assign imem_data_in = 16'h0000;
   assign imem_addr    = pc & ALIGN_MASK;
   assign imem_enable  = (state == ST_RUN) & ~fq_full;

   // Redirect wins over everything: no push, no pop in that cycle.
   assign fq_push        = imem_enable & ~redirect_valid;
   assign fq_pop         = inst_valid & inst_ready & ~redirect_valid;
   assign is_halt        = (imem_data_out[15:11] == 5'b00000);
   assign redirect_pc_al = redirect_pc & ALIGN_MASK;

   assign fq_in.pc   = imem_addr;
   assign fq_in.inst = imem_data_out;

   fetch_fifo #(
      .WIDTH ($bits(fq_entry_t)),
      .DEPTH (FQ_DEPTH)
   ) u_fq (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_valid),
      .push_vld (fq_push),
      .push_dat (fq_in),
      .pop      (fq_pop),
      .head_vld (inst_valid),
      .head_dat (fq_head),
      .full     (fq_full)
   );

   assign inst_out      = fq_head.inst;
   assign inst_pc       = fq_head.pc;
   assign inst_pc_plus2 = fq_head.pc + ADDR_WIDTH'(2);

   // PC: load aligned redirect target, otherwise step by 2 on every push (wraps).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= redirect_pc_al;
      end else if (fq_push) begin
         pc <= pc + ADDR_WIDTH'(2);
      end
   end

   // Fetch control FSM: one idle bubble after reset, halt on a fetched HALT, resume on redirect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         halted <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         err    <= 1'b0;
`endif
      end else if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
         // A misaligned target is fatal: flag it and park until reset or a clean redirect.
         if (redirect_pc[0]) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
            err    <= 1'b1;
         end else begin
            state  <= ST_RUN;
            halted <= 1'b0;
         end
`else
         state  <= ST_RUN;
         halted <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (fq_push && is_halt) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end
            end
            ST_HALTED: begin
               state <= ST_HALTED;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
